// File: rtl/video_timing_pkg.sv
// Shared definitions for the video raster timing generator.
// Contents: cfg_addr register map, reset-default timing, axis/timing-set structs
// and a helper that sums one axis into its total period.
// Timing fields are held in FieldW-bit containers so one struct type serves any
// HW up to FieldW. Fields narrower than FieldW are zero-extended.
package video_timing_pkg;

    localparam int unsigned FieldW = 16;
    // Totals and window bounds: four FieldW fields summed without overflow.
    localparam int unsigned TotW   = FieldW + 2;

    localparam logic [2:0] AddrHAct  = 3'd0;
    localparam logic [2:0] AddrHFp   = 3'd1;
    localparam logic [2:0] AddrHSync = 3'd2;
    localparam logic [2:0] AddrHBp   = 3'd3;
    localparam logic [2:0] AddrVAct  = 3'd4;
    localparam logic [2:0] AddrVFp   = 3'd5;
    localparam logic [2:0] AddrVSync = 3'd6;
    localparam logic [2:0] AddrVBp   = 3'd7;

    localparam logic [FieldW-1:0] DefHAct  = 16'd320;
    localparam logic [FieldW-1:0] DefHFp   = 16'd16;
    localparam logic [FieldW-1:0] DefHSync = 16'd32;
    localparam logic [FieldW-1:0] DefHBp   = 16'd48;
    localparam logic [FieldW-1:0] DefVAct  = 16'd240;
    localparam logic [FieldW-1:0] DefVFp   = 16'd3;
    localparam logic [FieldW-1:0] DefVSync = 16'd4;
    localparam logic [FieldW-1:0] DefVBp   = 16'd15;

    typedef struct packed {
        logic [FieldW-1:0] act;
        logic [FieldW-1:0] fp;
        logic [FieldW-1:0] sync;
        logic [FieldW-1:0] bp;
    } axis_cfg_t;

    typedef struct packed {
        axis_cfg_t h;
        axis_cfg_t v;
        logic      interlace;
    } timing_t;

    localparam timing_t TimingDefault = '{
        h:         '{act: DefHAct, fp: DefHFp, sync: DefHSync, bp: DefHBp},
        v:         '{act: DefVAct, fp: DefVFp, sync: DefVSync, bp: DefVBp},
        interlace: 1'b0
    };

    function automatic logic [TotW-1:0] axis_total(input axis_cfg_t a);
        return TotW'(a.act) + TotW'(a.fp) + TotW'(a.sync) + TotW'(a.bp);
    endfunction

endpackage

// File: rtl/vt_axis.sv
// One raster axis: next-count with wrap, plus blank and sync-window decode of the
// next count. Purely combinational; the top level owns the count register.
//   cnt_i   current count           clr_i  force next count to 0
//   step_i  advance this clock      last_i count value that wraps to 0
//   act_i/fp_i/sync_i  timing fields used to decode the next count
//   cnt_o   next count   wrap_o  cnt_i is at last_i
//   blank_o next count >= act   sync_o  next count in [act+fp, act+fp+sync)
// Kept as separate assigns so wrap_o never depends on the decode fields; the top
// selects those fields from wrap_o at a field boundary.
module vt_axis
    import video_timing_pkg::*;
#(
    parameter int unsigned HW = 12
) (
    input  logic [HW-1:0]     cnt_i,
    input  logic              clr_i,
    input  logic              step_i,
    input  logic [TotW-1:0]   last_i,
    input  logic [FieldW-1:0] act_i,
    input  logic [FieldW-1:0] fp_i,
    input  logic [FieldW-1:0] sync_i,
    output logic [HW-1:0]     cnt_o,
    output logic              wrap_o,
    output logic              blank_o,
    output logic              sync_o
);

    logic [TotW-1:0] nxt_ext;
    logic [TotW-1:0] sync_lo;
    logic [TotW-1:0] sync_hi;

    assign wrap_o  = (TotW'(cnt_i) == last_i);
    assign cnt_o   = clr_i ? '0 : (step_i ? (wrap_o ? '0 : cnt_i + 1'b1) : cnt_i);
    assign nxt_ext = TotW'(cnt_o);
    assign sync_lo = TotW'(act_i) + TotW'(fp_i);
    assign sync_hi = sync_lo + TotW'(sync_i);
    assign blank_o = (nxt_ext >= TotW'(act_i));
    assign sync_o  = (nxt_ext >= sync_lo) && (nxt_ext < sync_hi);

endmodule

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator with double-buffered timing registers.
//   clk_vid/reset            video clock, asynchronous active-high reset
//   ce_pix                   pixel enable; raster state advances only when high
//   cfg_we/cfg_addr/cfg_data staging register write port
//   cfg_interlace/cfg_commit staged interlace flag, request apply at field boundary
//   cfg_pending/cfg_err      commit outstanding / one-clock reject pulse
//   HSync/VSync              syncs at HS_POL/VS_POL active level
//   HBlank/VBlank/DE         blanking and data enable for the presented pixel
//   f1/hcnt/vcnt/new_frame   field, position, pulse on (0,0) of every field
// All flags are registered together with hcnt/vcnt, so they describe the same pixel.
// HW must not exceed video_timing_pkg::FieldW.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned HW     = 12,
    parameter logic        HS_POL = 1'b0,
    parameter logic        VS_POL = 1'b0
) (
    input  logic          clk_vid,
    input  logic          reset,
    input  logic          ce_pix,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_addr,
    input  logic [HW-1:0] cfg_data,
    input  logic          cfg_interlace,
    input  logic          cfg_commit,
    output logic          cfg_pending,
    output logic          cfg_err,
    output logic          HSync,
    output logic          VSync,
    output logic          HBlank,
    output logic          VBlank,
    output logic          DE,
    output logic          f1,
    output logic [HW-1:0] hcnt,
    output logic [HW-1:0] vcnt,
    output logic          new_frame
);

    localparam logic [TotW-1:0] TotMax = TotW'((1 << HW) - 1);

    timing_t       act_q, act_d, stg_q, stg_d;
    logic [HW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic          hblank_q, hblank_d, vblank_q, vblank_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d;
    logic          f1_q, f1_d, pending_q, pending_d;
    logic          new_frame_q, new_frame_d, cfg_err_q, cfg_err_d;
    logic          started_q, started_d;

    logic [TotW-1:0] htot, vtot, h_last, v_last, stg_htot, stg_vtot;
    logic [TotW-1:0] half_nxt, vs_lo, vs_hi, h_ext, v_ext;
    logic            running, restart, boundary, stg_ok, apply, reject, commit_take;
    logic [HW-1:0]   h_nxt, v_nxt;
    logic            h_wrap, v_wrap, h_blank, v_blank, h_sync, v_sync, vs_half;

    assign htot   = axis_total(act_q.h);
    assign vtot   = axis_total(act_q.v);
    assign h_last = htot - 1'b1;
    // Field 1 carries one extra blank line at the end of the back porch.
    assign v_last = f1_q ? vtot : vtot - 1'b1;

    // The first pixel enable after reset is itself a field boundary.
    assign running  = ce_pix & started_q;
    assign restart  = ce_pix & ~started_q;
    assign boundary = restart | (running & h_wrap & v_wrap);

    assign stg_htot = axis_total(stg_q.h);
    assign stg_vtot = axis_total(stg_q.v);
    assign stg_ok   = (stg_q.h.act != '0) && (stg_q.h.sync != '0) &&
                      (stg_q.v.act != '0) && (stg_q.v.sync != '0) &&
                      (stg_htot <= TotMax) && (stg_vtot + 1'b1 <= TotMax);

    assign apply       = boundary & pending_q & stg_ok;
    assign reject      = boundary & pending_q & ~stg_ok;
    assign commit_take = cfg_commit & (~pending_q | boundary);
    // A newly applied set already decodes (0,0) of the field it opens.
    assign act_d       = apply ? stg_q : act_q;

    vt_axis #(.HW(HW)) u_h_axis (
        .cnt_i   (hcnt_q),
        .clr_i   (restart),
        .step_i  (running),
        .last_i  (h_last),
        .act_i   (act_d.h.act),
        .fp_i    (act_d.h.fp),
        .sync_i  (act_d.h.sync),
        .cnt_o   (h_nxt),
        .wrap_o  (h_wrap),
        .blank_o (h_blank),
        .sync_o  (h_sync)
    );

    vt_axis #(.HW(HW)) u_v_axis (
        .cnt_i   (vcnt_q),
        .clr_i   (restart),
        .step_i  (running & h_wrap),
        .last_i  (v_last),
        .act_i   (act_d.v.act),
        .fp_i    (act_d.v.fp),
        .sync_i  (act_d.v.sync),
        .cnt_o   (v_nxt),
        .wrap_o  (v_wrap),
        .blank_o (v_blank),
        .sync_o  (v_sync)
    );

    // Field 1 VSync: same lines as field 0 but both edges move to mid-line.
    assign half_nxt = axis_total(act_d.h) >> 1;
    assign vs_lo    = TotW'(act_d.v.act) + TotW'(act_d.v.fp);
    assign vs_hi    = vs_lo + TotW'(act_d.v.sync);
    assign h_ext    = TotW'(h_nxt);
    assign v_ext    = TotW'(v_nxt);
    assign vs_half  = ((v_ext > vs_lo) || ((v_ext == vs_lo) && (h_ext >= half_nxt))) &&
                      ((v_ext < vs_hi) || ((v_ext == vs_hi) && (h_ext < half_nxt)));

    always_comb begin
        stg_d = stg_q;
        if (cfg_we) begin
            unique case (cfg_addr)
                AddrHAct:  stg_d.h.act  = FieldW'(cfg_data);
                AddrHFp:   stg_d.h.fp   = FieldW'(cfg_data);
                AddrHSync: stg_d.h.sync = FieldW'(cfg_data);
                AddrHBp:   stg_d.h.bp   = FieldW'(cfg_data);
                AddrVAct:  stg_d.v.act  = FieldW'(cfg_data);
                AddrVFp:   stg_d.v.fp   = FieldW'(cfg_data);
                AddrVSync: stg_d.v.sync = FieldW'(cfg_data);
                AddrVBp:   stg_d.v.bp   = FieldW'(cfg_data);
            endcase
        end
        if (commit_take) begin
            stg_d.interlace = cfg_interlace;
        end
    end

    always_comb begin
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        hblank_d    = hblank_q;
        vblank_d    = vblank_q;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        f1_d        = f1_q;
        pending_d   = pending_q;
        new_frame_d = boundary;
        cfg_err_d   = reject;
        started_d   = started_q | ce_pix;

        if (boundary) begin
            f1_d      = apply ? 1'b0 : (act_q.interlace & ~f1_q);
            pending_d = 1'b0;
        end
        if (commit_take) begin
            pending_d = 1'b1;
        end
        if (ce_pix) begin
            hcnt_d   = h_nxt;
            vcnt_d   = v_nxt;
            hblank_d = h_blank;
            vblank_d = v_blank;
            hsync_d  = h_sync;
            vsync_d  = f1_d ? vs_half : v_sync;
        end
    end

    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            act_q       <= TimingDefault;
            stg_q       <= TimingDefault;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            hblank_q    <= 1'b1;
            vblank_q    <= 1'b1;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            f1_q        <= 1'b0;
            pending_q   <= 1'b0;
            new_frame_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            started_q   <= 1'b0;
        end else begin
            act_q       <= act_d;
            stg_q       <= stg_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            hblank_q    <= hblank_d;
            vblank_q    <= vblank_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            f1_q        <= f1_d;
            pending_q   <= pending_d;
            new_frame_q <= new_frame_d;
            cfg_err_q   <= cfg_err_d;
            started_q   <= started_d;
        end
    end

    // hsync_q/vsync_q hold "sync active"; polarity is applied only at the pins.
    assign HSync       = HS_POL ? hsync_q : ~hsync_q;
    assign VSync       = VS_POL ? vsync_q : ~vsync_q;
    assign HBlank      = hblank_q;
    assign VBlank      = vblank_q;
    assign DE          = ~hblank_q & ~vblank_q;
    assign f1          = f1_q;
    assign hcnt        = hcnt_q;
    assign vcnt        = vcnt_q;
    assign new_frame   = new_frame_q;
    assign cfg_pending = pending_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen. Expected timing sets are hand-computed
// constants; the bench tracks the expected raster position clock by clock.
module tb_video_timing_gen;

    localparam int unsigned HW = 12;

    typedef struct {
        int ht;
        int vt;
        int hact;
        int hs_lo;
        int hs_hi;
        int vact;
        int vs_lo;
        int vs_hi;
        bit il;
    } tim_t;

    // 320/16/32/48 and 240/3/4/15
    localparam tim_t DefT   = '{ht: 416, vt: 262, hact: 320, hs_lo: 336, hs_hi: 368,
                                vact: 240, vs_lo: 243, vs_hi: 247, il: 1'b0};
    // H_ACT = 640 on top of defaults
    localparam tim_t WideDT = '{ht: 736, vt: 262, hact: 640, hs_lo: 656, hs_hi: 688,
                                vact: 240, vs_lo: 243, vs_hi: 247, il: 1'b0};
    // 8/2/3/3 and 6/1/2/2
    localparam tim_t SmallT = '{ht: 16, vt: 11, hact: 8, hs_lo: 10, hs_hi: 13,
                                vact: 6, vs_lo: 7, vs_hi: 9, il: 1'b0};
    // H_ACT = 12 on top of SmallT
    localparam tim_t WideT  = '{ht: 20, vt: 11, hact: 12, hs_lo: 14, hs_hi: 17,
                                vact: 6, vs_lo: 7, vs_hi: 9, il: 1'b0};
    localparam tim_t WideIT = '{ht: 20, vt: 11, hact: 12, hs_lo: 14, hs_hi: 17,
                                vact: 6, vs_lo: 7, vs_hi: 9, il: 1'b1};

    logic          clk_vid = 1'b0;
    logic          reset = 1'b0;
    logic          ce_pix = 1'b0;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_addr = '0;
    logic [HW-1:0] cfg_data = '0;
    logic          cfg_interlace = 1'b0;
    logic          cfg_commit = 1'b0;
    logic          cfg_pending, cfg_err, HSync, VSync, HBlank, VBlank, DE, f1, new_frame;
    logic [HW-1:0] hcnt, vcnt;

    video_timing_gen #(
        .HW     (HW),
        .HS_POL (1'b0),
        .VS_POL (1'b0)
    ) dut (
        .clk_vid       (clk_vid),
        .reset         (reset),
        .ce_pix        (ce_pix),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .cfg_interlace (cfg_interlace),
        .cfg_commit    (cfg_commit),
        .cfg_pending   (cfg_pending),
        .cfg_err       (cfg_err),
        .HSync         (HSync),
        .VSync         (VSync),
        .HBlank        (HBlank),
        .VBlank        (VBlank),
        .DE            (DE),
        .f1            (f1),
        .hcnt          (hcnt),
        .vcnt          (vcnt),
        .new_frame     (new_frame)
    );

    always #5 clk_vid = ~clk_vid;

    int    checks = 0;
    int    errors = 0;
    string ph = "init";

    tim_t cur;
    tim_t nxt;
    bit   nxt_ok;
    bit   e_started, e_pend, e_f1, e_nf, e_err;
    int   e_h, e_v;
    int   nf_seen, err_seen, f1_fields;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        bit hb, vb, hs, vs;
        int half;
        if (!e_started) begin
            hb = 1'b1;
            vb = 1'b1;
            hs = 1'b0;
            vs = 1'b0;
        end else begin
            hb   = (e_h >= cur.hact);
            vb   = (e_v >= cur.vact);
            hs   = (e_h >= cur.hs_lo) && (e_h < cur.hs_hi);
            half = cur.ht / 2;
            if (e_f1) begin
                vs = ((e_v > cur.vs_lo) || (e_v == cur.vs_lo && e_h >= half)) &&
                     ((e_v < cur.vs_hi) || (e_v == cur.vs_hi && e_h < half));
            end else begin
                vs = (e_v >= cur.vs_lo) && (e_v < cur.vs_hi);
            end
        end
        check_eq({ph, ".hcnt"}, int'(hcnt), e_h);
        check_eq({ph, ".vcnt"}, int'(vcnt), e_v);
        check_eq({ph, ".HBlank"}, int'(HBlank), int'(hb));
        check_eq({ph, ".VBlank"}, int'(VBlank), int'(vb));
        check_eq({ph, ".DE"}, int'(DE), int'(!hb && !vb));
        check_eq({ph, ".HSync"}, int'(HSync), int'(!hs));
        check_eq({ph, ".VSync"}, int'(VSync), int'(!vs));
        check_eq({ph, ".f1"}, int'(f1), int'(e_f1));
        check_eq({ph, ".new_frame"}, int'(new_frame), int'(e_nf));
        check_eq({ph, ".cfg_err"}, int'(cfg_err), int'(e_err));
        check_eq({ph, ".cfg_pending"}, int'(cfg_pending), int'(e_pend));
    endtask

    task automatic clk1(input bit ce, input bit we, input int addr, input int data,
                        input bit commit, input bit il);
        bit bnd;
        bit pend_pre;
        ce_pix        = ce;
        cfg_we        = we;
        cfg_addr      = addr[2:0];
        cfg_data      = data[HW-1:0];
        cfg_commit    = commit;
        cfg_interlace = il;
        @(posedge clk_vid);
        #1;
        ce_pix     = 1'b0;
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
        bnd      = 1'b0;
        pend_pre = e_pend;
        e_nf     = 1'b0;
        e_err    = 1'b0;
        if (ce) begin
            if (!e_started) begin
                e_started = 1'b1;
                e_h       = 0;
                e_v       = 0;
                bnd       = 1'b1;
            end else if (e_h == cur.ht - 1) begin
                e_h = 0;
                if (e_v == (e_f1 ? cur.vt : cur.vt - 1)) begin
                    e_v = 0;
                    bnd = 1'b1;
                end else begin
                    e_v++;
                end
            end else begin
                e_h++;
            end
            if (bnd) begin
                e_nf = 1'b1;
                if (e_pend && nxt_ok) begin
                    cur  = nxt;
                    e_f1 = 1'b0;
                end else begin
                    e_err = e_pend;
                    e_f1  = cur.il ? !e_f1 : 1'b0;
                end
                e_pend = 1'b0;
                if (e_f1) f1_fields++;
            end
        end
        if (commit && (!pend_pre || bnd)) e_pend = 1'b1;
        if (new_frame) nf_seen++;
        if (cfg_err) err_seen++;
        check_all();
    endtask

    task automatic run(input int n, input int per);
        for (int k = 0; k < n; k++) begin
            clk1((k % per) == 0, 1'b0, 0, 0, 1'b0, 1'b0);
        end
    endtask

    task automatic wr(input int addr, input int data);
        clk1(1'b0, 1'b1, addr, data, 1'b0, 1'b0);
    endtask

    task automatic commit(input bit il);
        clk1(1'b0, 1'b0, 0, 0, 1'b1, il);
    endtask

    // Asserted between clock edges to exercise the asynchronous path.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        e_started = 1'b0;
        e_pend    = 1'b0;
        e_f1      = 1'b0;
        e_nf      = 1'b0;
        e_err     = 1'b0;
        e_h       = 0;
        e_v       = 0;
        cur       = DefT;
        check_all();
        @(posedge clk_vid);
        #1;
        reset = 1'b0;
        check_all();
    endtask

    initial begin
        cur    = DefT;
        nxt    = DefT;
        nxt_ok = 1'b1;
        #1;
        ph = "reset";
        do_reset();

        // Default timing for two lines, then reset at hcnt = 100 with a commit pending.
        ph = "default";
        run(933, 1);
        check_eq("pos_before_rst.hcnt", int'(hcnt), 100);
        wr(0, 640);
        nxt    = WideDT;
        nxt_ok = 1'b1;
        commit(1'b0);
        ph = "midrst";
        do_reset();
        // Staging must be back at defaults: this commit applies 416-wide lines.
        nxt = DefT;
        commit(1'b0);
        ph = "after_rst";
        run(420, 1);

        // Pixel enable 1-in-4: same position sequence, outputs hold in between.
        ph = "ce4";
        do_reset();
        nf_seen = 0;
        run(1800, 4);
        check_eq("ce4.new_frame_pulses", nf_seen, 1);

        // Program a small raster while ce_pix is low, applied on the first enable.
        ph = "small";
        do_reset();
        wr(0, 8);
        wr(1, 2);
        wr(2, 3);
        wr(3, 3);
        wr(4, 6);
        wr(5, 1);
        wr(6, 2);
        wr(7, 2);
        nxt    = SmallT;
        nxt_ok = 1'b1;
        commit(1'b0);
        nf_seen = 0;
        run(352, 1);
        check_eq("small.frames", nf_seen, 2);

        // Mid-frame H_ACT change lands only at the next (0,0).
        ph = "hact";
        run(50, 1);
        wr(0, 12);
        nxt    = WideT;
        nxt_ok = 1'b1;
        commit(1'b0);
        run(400, 1);
        check_eq("hact.pending_clear", int'(cfg_pending), 0);

        // V_SYNC = 0 is rejected: one cfg_err pulse, timing kept.
        ph = "badsync";
        wr(6, 0);
        nxt_ok   = 1'b0;
        err_seen = 0;
        commit(1'b0);
        run(500, 1);
        check_eq("badsync.err_pulses", err_seen, 1);
        wr(6, 2);

        // Interlace: alternating 220/240-clock fields, mid-line VSync edges on f1.
        ph = "interlace";
        nxt       = WideIT;
        nxt_ok    = 1'b1;
        f1_fields = 0;
        commit(1'b1);
        run(1000, 1);
        check_eq("interlace.f1_fields", f1_fields, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
